// File: rtl/sync_fifo_ctrl_if.sv
// Command/status bundle between a FIFO producer/consumer driver and the
// sync_fifo_ctrl responder.
interface sync_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  clr;
  logic                  wr;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, wr, din, rd,
    input  dout, dout_valid, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  clr, wr, din, rd,
    output dout, dout_valid, full, empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO over a register array: registered read data, occupancy
// count, count-derived flags and one-cycle overflow/underflow pulses.
module sync_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned AFULL_LEVEL = 14
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty, wr_ok, rd_ok, wr_en;

  always_comb begin
    full  = (count_q == DEPTH_CNT);
    empty = (count_q == '0);
    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
    wr_ok = bus.wr & (~full | bus.rd);
    rd_ok = bus.rd & ~empty;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    wr_en        = 1'b0;

    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      overflow_d  = bus.wr & ~wr_ok;
      underflow_d = bus.rd & empty;
      wr_en       = wr_ok;
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_ok) begin
        rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(1);
        dout_d       = mem_q[rd_ptr_q];
        dout_valid_d = 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is not reset, but a write must not land while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) mem_q[wr_ptr_q] <= bus.din;
  end

  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (count_q >= AFULL_CNT);
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_sync_fifo_ctrl;
  localparam int DEPTH = 16;
  localparam int AFULL = 14;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_LEVEL(AFULL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue plus the visible registered outputs.
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_dv, m_ovf, m_udf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = 8'h00;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic model_update(input logic c, input logic w, input logic r, input logic [7:0] d);
    int  n;
    bit  was_full, was_empty;
    n         = q.size();
    was_full  = (n == DEPTH);
    was_empty = (n == 0);
    if (c) begin
      q.delete();
      m_dv  = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_ovf = w && was_full && !r;
      m_udf = r && was_empty;
      m_dv  = 1'b0;
      if (r && !was_empty) begin
        m_dout = q.pop_front();
        m_dv   = 1'b1;
      end
      if (w && (!was_full || r)) q.push_back(d);
    end
  endtask

  task automatic check_model();
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
    chk("almost_full", 32'(bus.almost_full), 32'(q.size() >= AFULL));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_udf));
    chk("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
    chk("dout", 32'(bus.dout), 32'(m_dout));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 0);
    chk({tag, "_empty"}, 32'(bus.empty), 1);
    chk({tag, "_full"}, 32'(bus.full), 0);
    chk({tag, "_afull"}, 32'(bus.almost_full), 0);
    chk({tag, "_ovf"}, 32'(bus.overflow), 0);
    chk({tag, "_udf"}, 32'(bus.underflow), 0);
    chk({tag, "_dv"}, 32'(bus.dout_valid), 0);
    chk({tag, "_dout"}, 32'(bus.dout), 0);
  endtask

  task automatic step(input logic c, input logic w, input logic r, input logic [7:0] d);
    bus.clr = c;
    bus.wr  = w;
    bus.rd  = r;
    bus.din = d;
    @(posedge clk);
    model_update(c, w, r, d);
    #1;
    check_model();
    bus.clr = 1'b0;
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
  endtask

  // Invariant monitor, sampled mid-cycle.
  logic prev_rd_ok;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_rd_ok <= 1'b0;
    else        prev_rd_ok <= bus.rd && !bus.empty && !bus.clr;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_count_le_depth", 32'(bus.count <= 5'(DEPTH)), 1);
      chk("inv_not_full_and_empty", 32'(!(bus.full && bus.empty)), 1);
      chk("inv_dv_implies_prev_rd", 32'(!bus.dout_valid || prev_rd_ok), 1);
    end
  end

  typedef struct {
    logic       clr, wr, rd;
    logic [7:0] din;
    int         e_count;
    logic       e_empty, e_full, e_ovf, e_udf, e_dv;
    logic [7:0] e_dout;
  } vec_t;

  vec_t       vecs[14];
  logic [7:0] fdat[16];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h22, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h33, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h44, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h55, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h66, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h77, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h88, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h99, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99};

    rst_n   = 1'b0;
    bus.clr = 1'b0;
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
    bus.din = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Vector table: clr with every wr/rd combination, dout held across clr.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk("vec_count", 32'(bus.count), 32'(vecs[i].e_count));
      chk("vec_empty", 32'(bus.empty), 32'(vecs[i].e_empty));
      chk("vec_full", 32'(bus.full), 32'(vecs[i].e_full));
      chk("vec_ovf", 32'(bus.overflow), 32'(vecs[i].e_ovf));
      chk("vec_udf", 32'(bus.underflow), 32'(vecs[i].e_udf));
      chk("vec_dv", 32'(bus.dout_valid), 32'(vecs[i].e_dv));
      chk("vec_dout", 32'(bus.dout), 32'(vecs[i].e_dout));
    end

    // Fill to full, then one rejected write.
    for (int i = 0; i < 15; i++) begin
      fdat[i] = 8'($urandom);
      step(1'b0, 1'b1, 1'b0, fdat[i]);
      chk("fill_afull", 32'(bus.almost_full), 32'((i + 1) >= AFULL));
    end
    chk("fill15_count", 32'(bus.count), 15);
    chk("fill15_full", 32'(bus.full), 0);
    fdat[15] = 8'($urandom);
    step(1'b0, 1'b1, 1'b0, fdat[15]);
    chk("fill16_full", 32'(bus.full), 1);
    chk("fill16_count", 32'(bus.count), 16);
    step(1'b0, 1'b1, 1'b0, 8'hEE);
    chk("fill17_ovf", 32'(bus.overflow), 1);
    chk("fill17_count", 32'(bus.count), 16);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_one_cycle", 32'(bus.overflow), 0);

    // Drain in order, then one rejected read.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("drain_dout", 32'(bus.dout), 32'(fdat[i]));
      chk("drain_dv", 32'(bus.dout_valid), 1);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("drain17_udf", 32'(bus.underflow), 1);
    chk("drain17_dv", 32'(bus.dout_valid), 0);
    chk("drain17_dout", 32'(bus.dout), 32'(fdat[15]));
    chk("drain17_empty", 32'(bus.empty), 1);

    // Pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    chk("wrap_full", 32'(bus.full), 1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("wrap_dout", 32'(bus.dout), 32'(i));
    end
    chk("wrap_empty", 32'(bus.empty), 1);

    // Simultaneous wr/rd at full and at empty.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    chk("simfull_count", 32'(bus.count), 16);
    chk("simfull_ovf", 32'(bus.overflow), 0);
    chk("simfull_dout", 32'(bus.dout), 32'h10);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("simfull_last", 32'(bus.dout), 32'hA5);
    step(1'b0, 1'b1, 1'b1, 8'h3C);
    chk("simempty_udf", 32'(bus.underflow), 1);
    chk("simempty_count", 32'(bus.count), 1);
    chk("simempty_dv", 32'(bus.dout_valid), 0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("simempty_dout", 32'(bus.dout), 32'h3C);

    // Asynchronous reset between edges with data in flight.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
    chk("pre_reset_count", 32'(bus.count), 8);
    bus.wr  = 1'b1;
    bus.din = 8'hDD;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("async");
    model_reset();
    @(posedge clk);
    #1;
    check_reset("async_held");
    bus.wr = 1'b0;
    #2;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("post_reset_dout", 32'(bus.dout), 32'h77);

    // Randomized traffic against the model, alternating fill-heavy and drain-heavy phases.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int   wp;
      logic c, w, r;
      wp = ((cyc / 250) % 2 == 0) ? 75 : 30;
      c  = ($urandom_range(0, 63) == 0);
      w  = ($urandom_range(0, 99) < wp);
      r  = ($urandom_range(0, 99) < (100 - wp));
      step(c, w, r, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
